// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with load-use hazard bubble insertion
// Optional bubble counter enabled by defining STALL_COUNTER_EN.
module id_ex_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            id_valid,
  input  logic [14:0]     id_ctrl,
  input  logic [XLEN-1:0] id_pc,
  input  logic [XLEN-1:0] id_rs1_data,
  input  logic [XLEN-1:0] id_rs2_data,
  input  logic [XLEN-1:0] id_imm,
  input  logic [4:0]      id_rs1,
  input  logic [4:0]      id_rs2,
  input  logic [4:0]      id_rd,
  input  logic            flush,
  input  logic            ex_hold,
  output logic            stall_out,
  output logic            ex_valid,
  output logic [14:0]     ex_ctrl,
  output logic [XLEN-1:0] ex_pc,
  output logic [XLEN-1:0] ex_rs1_data,
  output logic [XLEN-1:0] ex_rs2_data,
  output logic [XLEN-1:0] ex_imm,
  output logic [4:0]      ex_rs1,
  output logic [4:0]      ex_rs2,
  output logic [4:0]      ex_rd,
  output logic [15:0]     stall_cnt
);

  logic            r_valid;
  logic [14:0]     r_ctrl;
  logic [XLEN-1:0] r_pc, r_rs1_data, r_rs2_data, r_imm;
  logic [4:0]      r_rs1, r_rs2, r_rd;
  logic            w_hazard;
  logic            w_bubble;

  // Load in EX whose destination feeds the instruction waiting in ID.
  assign w_hazard = id_valid & r_valid & r_ctrl[12] & (r_rd != 5'd0) &
                    ((r_rd == id_rs1) | (r_rd == id_rs2));
  assign w_bubble = w_hazard & ~flush & ~ex_hold;
  assign stall_out = w_hazard & ~flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid    <= 1'b0;
      r_ctrl     <= '0;
      r_pc       <= '0;
      r_rs1_data <= '0;
      r_rs2_data <= '0;
      r_imm      <= '0;
      r_rs1      <= '0;
      r_rs2      <= '0;
      r_rd       <= '0;
    end else if (flush || (!ex_hold && w_hazard)) begin
      r_valid    <= 1'b0;
      r_ctrl     <= '0;
      r_pc       <= '0;
      r_rs1_data <= '0;
      r_rs2_data <= '0;
      r_imm      <= '0;
      r_rs1      <= '0;
      r_rs2      <= '0;
      r_rd       <= '0;
    end else if (!ex_hold) begin
      r_valid    <= id_valid;
      r_ctrl     <= id_valid ? id_ctrl : 15'd0;
      r_pc       <= id_pc;
      r_rs1_data <= id_rs1_data;
      r_rs2_data <= id_rs2_data;
      r_imm      <= id_imm;
      r_rs1      <= id_rs1;
      r_rs2      <= id_rs2;
      r_rd       <= id_rd;
    end
  end

`ifdef STALL_COUNTER_EN
  logic [15:0] r_stall_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
    end else if (w_bubble && (r_stall_cnt != 16'hFFFF)) begin
      r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  assign stall_cnt = r_stall_cnt;
`else
  logic w_unused_bubble;
  assign w_unused_bubble = w_bubble;
  assign stall_cnt = 16'd0;
`endif

  assign ex_valid    = r_valid;
  assign ex_ctrl     = r_ctrl;
  assign ex_pc       = r_pc;
  assign ex_rs1_data = r_rs1_data;
  assign ex_rs2_data = r_rs2_data;
  assign ex_imm      = r_imm;
  assign ex_rs1      = r_rs1;
  assign ex_rs2      = r_rs2;
  assign ex_rd       = r_rd;

endmodule
